operand_bypass_rf: RTL
======================

// Module: operand_bypass_rf
// PURPOSE
//  Parametrised decode-stage operand unit: NUM_RD-read/1-write register file, NUM_FWD-deep forwarding,
//  load-use hazard detection and a valid/ready output register toward EXE.
//  Sits between IF/ID and EXE. Separate forwarding, regfile and stall-masking logic collapse into one block.
// PARAMETERS
//  DATA_W   32  operand / register width
//  ADDR_W   5   register address width; RF depth = 2**ADDR_W
//  NUM_RD   2   read ports (operands per instruction)
//  NUM_FWD  3   forwarding sources; index 0 = youngest (EXE), NUM_FWD-1 = oldest
// PORTS
//  clk          in   1                   clock, rising edge
//  rst          in   1                   asynchronous reset, active-low
//  wb_we        in   1                   writeback write enable
//  wb_waddr     in   ADDR_W              writeback register address
//  wb_wdata     in   DATA_W              writeback data
//  rd_addr      in   NUM_RD*ADDR_W       operand addresses, port k at [k*ADDR_W +: ADDR_W]
//  fwd_we       in   NUM_FWD             stage i will write a register
//  fwd_pend     in   NUM_FWD             stage i result not yet available (load in flight)
//  fwd_waddr    in   NUM_FWD*ADDR_W      stage i destination
//  fwd_wdata    in   NUM_FWD*DATA_W      stage i result (valid when !fwd_pend[i])
//  id_valid     in   1                   decode holds a valid instruction
//  id_ready     out  1                   operands captured this cycle
//  flush        in   1                   branch-mispredict / exception kill
//  ex_ready     in   1                   EXE accepts the output register
//  ex_valid     out  1                   output register holds valid operands
//  ex_rdata     out  NUM_RD*DATA_W       registered resolved operands
//  hazard       out  1                   combinational load-use stall
//  stall_cnt    out  32                  saturating count of hazard stall cycles
// BEHAVIOUR
//  Reset (rst=0, async): all RF entries 0, ex_valid=0, ex_rdata=0, stall_cnt=0.
//  RF write: rising clk with wb_we=1 and wb_waddr!=0 writes wb_wdata; reg 0 never written, reads 0.
//  Operand k resolution, first hit wins:
//    1. addr==0 -> 0, never hazards
//    2. youngest i with fwd_we[i] && fwd_waddr[i]==addr:
//         fwd_pend[i]=0 -> fwd_wdata[i]; fwd_pend[i]=1 -> hazard
//    3. wb_we && wb_waddr==addr -> wb_wdata (same-cycle write-through)
//    4. RF[addr]
//  A pending older stage shadowed by a younger matching non-pending stage causes no hazard.
//  hazard = id_valid & any operand hit a pending stage (step 2).
//  id_ready = id_valid & !hazard & !flush & (!ex_valid | ex_ready).
//  Output register, rising clk, priority order:
//    flush              -> ex_valid<=0, ex_rdata holds
//    id_ready           -> ex_valid<=1, ex_rdata<=resolved operands (1-cycle latency)
//    ex_valid&ex_ready  -> ex_valid<=0
//    else               -> hold
//  flush does not block the RF write in the same cycle.
//  stall_cnt += 1 on each rising clk with hazard & !flush; saturates at 32'hFFFF_FFFF, no wrap.
//  Reset asserted mid-transfer drops ex_valid immediately; no partial capture.
// TESTING
//  T1 reset: rst=0 then 1; read r1..r31 -> all 0, ex_valid=0, stall_cnt=0.
//  T2 fwd priority: RF[5]=0x11, WB r5=0x22, fwd[2] r5=0x33, fwd[0] r5=0x44 -> ex_rdata port0=0x44
//     next cycle; drop fwd[0] -> 0x33.
//  T3 load-use: fwd[0] r7 pend=1, id reads r7 -> hazard=1, id_ready=0, stall_cnt increments.
//     Clear pend with wdata=0xAB -> captured 0xAB.
//  T4 shadowing: fwd[1] r7 pend=1, fwd[0] r7 pend=0 wdata=0x5 -> no hazard, operand=0x5.
//  T5 backpressure/flush: ex_valid=1, ex_ready=0 -> id_ready=0, ex_rdata stable 3 cycles;
//     flush=1 -> ex_valid=0 next edge while WB r3=0x9 still lands in RF.
//  T6 r0 and saturation: WB r0=0xFF then read r0 -> 0; preload stall_cnt at max,
//     hazard 2 cycles -> stays 0xFFFF_FFFF.

Source files
------------

// File: rtl/operand_bypass_rf.sv
// rtl/operand_bypass_rf.sv - decode-stage register file with forwarding, load-use stall and EXE output register
module operand_bypass_rf #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_we,
    input  logic [ADDR_W-1:0]         wb_waddr,
    input  logic [DATA_W-1:0]         wb_wdata,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD-1:0]        fwd_pend,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic                      flush,
    input  logic                      ex_ready,
    output logic                      ex_valid,
    output logic [NUM_RD*DATA_W-1:0]  ex_rdata,
    output logic                      hazard,
    output logic [31:0]               stall_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        rf_q [DEPTH];
    logic [DATA_W-1:0]        rf_d [DEPTH];
    logic                     ex_valid_q, ex_valid_d;
    logic [NUM_RD*DATA_W-1:0] ex_rdata_q, ex_rdata_d;
    logic [31:0]              stall_cnt_q, stall_cnt_d;

    logic [NUM_RD*DATA_W-1:0] resolved;
    logic                     any_pend;

    // Register file next state: writeback lands unless it targets r0.
    always_comb begin
        rf_d = rf_q;
        if (wb_we && (wb_waddr != '0)) begin
            rf_d[wb_waddr] = wb_wdata;
        end
    end

    // Operand resolution: r0, then youngest matching forward stage, then writeback write-through, then RF.
    always_comb begin
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;
        logic              hit;
        resolved = '0;
        any_pend = 1'b0;
        addr     = '0;
        val      = '0;
        hit      = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            addr = rd_addr[k*ADDR_W +: ADDR_W];
            val  = '0;
            hit  = 1'b0;
            if (addr != '0) begin
                for (int i = 0; i < NUM_FWD; i++) begin
                    if (!hit && fwd_we[i] && (fwd_waddr[i*ADDR_W +: ADDR_W] == addr)) begin
                        hit = 1'b1;
                        if (fwd_pend[i]) begin
                            any_pend = 1'b1;
                        end else begin
                            val = fwd_wdata[i*DATA_W +: DATA_W];
                        end
                    end
                end
                if (!hit) begin
                    if (wb_we && (wb_waddr == addr)) begin
                        val = wb_wdata;
                    end else begin
                        val = rf_q[addr];
                    end
                end
            end
            resolved[k*DATA_W +: DATA_W] = val;
        end
    end

    assign hazard   = id_valid & any_pend;
    assign id_ready = id_valid & ~hazard & ~flush & (~ex_valid_q | ex_ready);

    // Output register handshake: flush kills, capture on id_ready, drain on ex_ready.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rdata_d = ex_rdata_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (id_ready) begin
            ex_valid_d = 1'b1;
            ex_rdata_d = resolved;
        end else if (ex_valid_q && ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // Stall counter counts unflushed hazard cycles and sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                rf_q[j] <= '0;
            end
            ex_valid_q  <= 1'b0;
            ex_rdata_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            rf_q        <= rf_d;
            ex_valid_q  <= ex_valid_d;
            ex_rdata_q  <= ex_rdata_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_rdata  = ex_rdata_q;
    assign stall_cnt = stall_cnt_q;

endmodule
